// File: rtl/fnv_hasher_fsm.sv
// FNV-1a hash sequencer: pops length-prefixed messages from the byte FIFO,
// folds each payload byte into a 32-bit hash and pushes the result to the word FIFO.
module fnv_hasher_fsm #(
  parameter logic [31:0] OFFSET_BASIS = 32'h811C_9DC5,
  parameter logic [31:0] FNV_PRIME    = 32'h0100_0193
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  in_rdata,
  input  logic        in_rempty,
  output logic        in_rinc,
  output logic [31:0] out_wdata,
  input  logic        out_wfull,
  output logic        out_winc,
  output logic        busy,
  output logic [7:0]  msg_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ABSORB = 2'b01,
    S_PUSH   = 2'b10
  } state_t;

  state_t      r_state;
  logic [31:0] r_hash;
  logic [7:0]  r_remaining;
  logic [7:0]  r_msg_count;
  logic [31:0] w_xor;
  logic [31:0] w_mul;

  assign w_xor = r_hash ^ {24'b0, in_rdata};

  // Standard prime folds to a shift-add; any other prime falls back to a plain multiply.
  generate
    if (FNV_PRIME == 32'h0100_0193) begin : g_shift_add
      assign w_mul = w_xor + (w_xor << 1) + (w_xor << 4) + (w_xor << 7)
                   + (w_xor << 8) + (w_xor << 24);
    end else begin : g_generic_mul
      assign w_mul = w_xor * FNV_PRIME;
    end
  endgenerate

  // Strobes are gated by reset and clear so neither FIFO is touched while aborting.
  assign in_rinc   = ~reset & ~clear & ~in_rempty &
                     ((r_state == S_IDLE) | (r_state == S_ABSORB));
  assign out_winc  = ~reset & ~clear & ~out_wfull & (r_state == S_PUSH);
  assign out_wdata = r_hash;
  assign busy      = (r_state != S_IDLE);
  assign msg_count = r_msg_count;

  // Message sequencer: hash, byte counter and push counter.
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hash      <= OFFSET_BASIS;
      r_remaining <= 8'd0;
      r_msg_count <= 8'd0;
    end else if (clear) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!in_rempty) begin
            r_remaining <= in_rdata;
            r_hash      <= OFFSET_BASIS;
            r_state     <= (in_rdata == 8'd0) ? S_PUSH : S_ABSORB;
          end
        end
        S_ABSORB: begin
          if (!in_rempty) begin
            r_hash      <= w_mul;
            r_remaining <= r_remaining - 8'd1;
            if (r_remaining == 8'd1) begin
              r_state <= S_PUSH;
            end
          end
        end
        S_PUSH: begin
          if (!out_wfull) begin
            r_msg_count <= r_msg_count + 8'd1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fnv_hasher_fsm.sv
// Directed bench for fnv_hasher_fsm: a queue models the byte FIFO and pushes are logged per cycle.
module tb_fnv_hasher_fsm;

  logic        system_clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [7:0]  in_rdata;
  logic        in_rempty;
  logic        in_rinc;
  logic [31:0] out_wdata;
  logic        out_wfull;
  logic        out_winc;
  logic        busy;
  logic [7:0]  msg_count;

  fnv_hasher_fsm dut (
    .system_clk (system_clk),
    .reset      (reset),
    .clear      (clear),
    .in_rdata   (in_rdata),
    .in_rempty  (in_rempty),
    .in_rinc    (in_rinc),
    .out_wdata  (out_wdata),
    .out_wfull  (out_wfull),
    .out_winc   (out_winc),
    .busy       (busy),
    .msg_count  (msg_count)
  );

  always #5 system_clk = ~system_clk;

  logic [7:0]  fifo[$];
  logic [31:0] pushes[$];
  int          push_cyc[$];
  bit          busy_log[0:1023];
  bit          rinc_log[0:1023];
  int          cyc_n;
  int          viol;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] push_data(input int i);
    return (pushes.size() > i) ? pushes[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic int push_at(input int i);
    return (push_cyc.size() > i) ? push_cyc[i] : -1;
  endfunction

  task automatic start_test();
    pushes.delete();
    push_cyc.delete();
    cyc_n = 0;
    viol  = 0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick(input bit f_empty, input bit f_full, input bit f_clr);
    logic        s_rinc;
    logic        s_winc;
    logic [31:0] s_wdata;
    logic [7:0]  dummy;
    in_rempty = (fifo.size() == 0) || f_empty;
    in_rdata  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    out_wfull = f_full;
    clear     = f_clr;
    #1;
    if (cyc_n < 1024) begin
      busy_log[cyc_n] = busy;
      rinc_log[cyc_n] = in_rinc;
    end
    if (out_winc && out_wfull) viol++;
    if (in_rinc && in_rempty) viol++;
    s_rinc  = in_rinc;
    s_winc  = out_winc;
    s_wdata = out_wdata;
    @(posedge system_clk);
    if (s_rinc) dummy = fifo.pop_front();
    if (s_winc) begin
      pushes.push_back(s_wdata);
      push_cyc.push_back(cyc_n);
    end
    @(negedge system_clk);
    cyc_n++;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    reset     = 1'b1;
    clear     = 1'b0;
    in_rempty = 1'b0;
    in_rdata  = 8'h5A;
    out_wfull = 1'b0;
    #12;
    chk("rst_rinc",  {31'd0, in_rinc},  32'd0);
    chk("rst_winc",  {31'd0, out_winc}, 32'd0);
    chk("rst_busy",  {31'd0, busy},     32'd0);
    chk("rst_wdata", out_wdata,         32'h811C_9DC5);
    chk("rst_count", {24'd0, msg_count}, 32'd0);
    @(negedge system_clk);
    reset = 1'b0;

    // Zero-length message
    start_test();
    fifo = '{8'h00};
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, 1'b0);
    chk("l0_npush", pushes.size(), 32'd1);
    chk("l0_data",  push_data(0), 32'h811C_9DC5);
    chk("l0_cycle", push_at(0), 32'd1);
    chk("l0_count", {24'd0, msg_count}, 32'd1);

    // Single byte 'a'
    start_test();
    fifo = '{8'h01, 8'h61};
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b0, 1'b0);
    chk("a_data",  push_data(0), 32'hE40C_292C);
    chk("a_cycle", push_at(0), 32'd2);
    chk("a_busy1", {31'd0, busy_log[1]}, 32'd1);
    chk("a_busy2", {31'd0, busy_log[2]}, 32'd1);
    chk("a_busy3", {31'd0, busy_log[3]}, 32'd0);
    chk("a_count", {24'd0, msg_count}, 32'd2);

    // "foobar" with a 3-cycle empty gap after the first 'o'
    start_test();
    fifo = '{8'h06, 8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
    for (int c = 0; c < 12; c++) tick((c >= 3) && (c <= 5), 1'b0, 1'b0);
    chk("fb_npush", pushes.size(), 32'd1);
    chk("fb_data",  push_data(0), 32'hBF9C_F968);
    chk("fb_cycle", push_at(0), 32'd10);
    chk("fb_gap",   {29'd0, rinc_log[3], rinc_log[4], rinc_log[5]}, 32'd0);
    chk("fb_rinc6", {31'd0, rinc_log[6]}, 32'd1);

    // Back-to-back with output full for 4 cycles at first push
    start_test();
    fifo = '{8'h01, 8'h61, 8'h00};
    for (int c = 0; c < 10; c++) tick(1'b0, (c >= 2) && (c <= 5), 1'b0);
    chk("bb_npush",  pushes.size(), 32'd2);
    chk("bb_data0",  push_data(0), 32'hE40C_292C);
    chk("bb_cycle0", push_at(0), 32'd6);
    chk("bb_data1",  push_data(1), 32'h811C_9DC5);
    chk("bb_cycle1", push_at(1), 32'd8);
    chk("bb_viol",   viol, 32'd0);
    chk("bb_count",  {24'd0, msg_count}, 32'd5);

    // Clear after three payload bytes of "foobar"
    start_test();
    fifo = '{8'h06, 8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
    for (int c = 0; c < 11; c++) tick(1'b0, 1'b0, c == 4);
    chk("clr_rinc4", {31'd0, rinc_log[4]}, 32'd0);
    chk("clr_busy5", {31'd0, busy_log[5]}, 32'd0);
    chk("clr_rinc5", {31'd0, rinc_log[5]}, 32'd1);
    chk("clr_npush", pushes.size(), 32'd0);
    chk("clr_fifo",  fifo.size(), 32'd0);
    chk("clr_busy",  {31'd0, busy}, 32'd1);
    chk("clr_count", {24'd0, msg_count}, 32'd5);
    chk("clr_viol",  viol, 32'd0);

    // Asynchronous reset mid-ABSORB, checked before any clock edge
    fifo      = '{8'h11, 8'h22};
    in_rempty = 1'b0;
    in_rdata  = 8'h11;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy",  {31'd0, busy},      32'd0);
    chk("ar_rinc",  {31'd0, in_rinc},   32'd0);
    chk("ar_winc",  {31'd0, out_winc},  32'd0);
    chk("ar_wdata", out_wdata,          32'h811C_9DC5);
    chk("ar_count", {24'd0, msg_count}, 32'd0);
    @(negedge system_clk);
    reset = 1'b0;
    fifo.delete();

    // 256 single-byte messages wrap the push counter
    start_test();
    for (int m = 0; m < 256; m++) begin
      fifo.push_back(8'h01);
      fifo.push_back(8'h61);
    end
    for (int c = 0; c < 256 * 3 + 4; c++) tick(1'b0, 1'b0, 1'b0);
    chk("wr_npush",  pushes.size(), 32'd256);
    chk("wr_first",  push_data(0), 32'hE40C_292C);
    chk("wr_last",   push_data(255), 32'hE40C_292C);
    chk("wr_lastcy", push_at(255), 32'd767);
    chk("wr_count",  {24'd0, msg_count}, 32'd0);
    chk("wr_viol",   viol, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
